msrv32_reg_file_mp: RTL and testbench

- Parametrised multi-port integer register file for the msrv32 core.
- Serves NRD read ports to pipeline stage 2 and two write-back ports from stage 3: port A for ALU/CSR results, port B for the load unit.
- Adds a per-register busy scoreboard for hazard detection.
- Adds a sequential clear engine so the file can be zeroed after a soft flush without asserting reset.

---
 rtl/msrv32_reg_file_mp.sv | 83 ++++++++
 tb/tb_msrv32_reg_file_mp.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_reg_file_mp.sv
// msrv32_reg_file_mp: multi-port register file with busy scoreboard and sequential clear engine.
// Define MSRV32_RF_FWD_EN to forward same-cycle write data to the read ports.
module msrv32_reg_file_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic                       ms_riscv32_mp_clk_in,
    input  logic                       ms_riscv32_mp_rst_n_in,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr_in,
    output logic [NRD*XLEN-1:0]        rd_data_out,
    output logic [NRD-1:0]             rd_busy_out,
    input  logic                       wa_en_in,
    input  logic [$clog2(NREGS)-1:0]   wa_addr_in,
    input  logic [XLEN-1:0]            wa_data_in,
    input  logic                       wb_en_in,
    input  logic [$clog2(NREGS)-1:0]   wb_addr_in,
    input  logic [XLEN-1:0]            wb_data_in,
    input  logic                       iss_en_in,
    input  logic [$clog2(NREGS)-1:0]   iss_rd_in,
    input  logic                       clr_req_in,
    output logic                       clr_busy_out
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [AW-1:0]     cnt;
    logic              idle, wa_we, wb_we;

    assign idle         = state == IDLE;
    assign wa_we        = idle && wa_en_in && wa_addr_in != '0;
    assign wb_we        = idle && wb_en_in && wb_addr_in != '0;
    assign clr_busy_out = !idle;

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= '0;
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (!idle) begin
                    if (cnt == AW'(r)) regs[r] <= '0;
                end else if (wb_we && wb_addr_in == AW'(r)) regs[r] <= wb_data_in;
                else if (wa_we && wa_addr_in == AW'(r)) regs[r] <= wa_data_in;
                // issue beats write-back so a re-issued destination stays busy
                if (idle && clr_req_in) busy[r] <= 1'b0;
                else if (idle && iss_en_in && iss_rd_in == AW'(r)) busy[r] <= 1'b1;
                else if ((wa_we && wa_addr_in == AW'(r)) || (wb_we && wb_addr_in == AW'(r))) busy[r] <= 1'b0;
            end
            if (idle) begin
                if (clr_req_in) begin
                    state <= CLEAR;
                    cnt   <= AW'(1);
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == AW'(NREGS - 1)) state <= IDLE;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            hit_a, hit_b;
        assign a     = rd_addr_in[k*AW +: AW];
        assign hit_a = wa_we && wa_addr_in == a;
        assign hit_b = wb_we && wb_addr_in == a;
`ifdef MSRV32_RF_FWD_EN
        assign d = hit_b ? wb_data_in : hit_a ? wa_data_in : regs[a];
`else
        assign d = regs[a];
`endif
        assign rd_data_out[k*XLEN +: XLEN] = (!ms_riscv32_mp_rst_n_in || a == '0) ? '0 : d;
        assign rd_busy_out[k] = ms_riscv32_mp_rst_n_in && busy[a] && !(hit_a || hit_b);
    end
endmodule

// File: tb/tb_msrv32_reg_file_mp.sv
// tb_msrv32_reg_file_mp: scoreboard bench for msrv32_reg_file_mp (default parameters).
module tb_msrv32_reg_file_mp;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wa_en = 0, wb_en = 0, iss_en = 0, clr_req = 0;
    logic [AW-1:0]       wa_addr = 0, wb_addr = 0, iss_rd = 0;
    logic [XLEN-1:0]     wa_data = 0, wb_data = 0;
    logic                clr_busy;

    always #5 clk = ~clk;

    msrv32_reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
        .rd_addr_in(rd_addr), .rd_data_out(rd_data), .rd_busy_out(rd_busy),
        .wa_en_in(wa_en), .wa_addr_in(wa_addr), .wa_data_in(wa_data),
        .wb_en_in(wb_en), .wb_addr_in(wb_addr), .wb_data_in(wb_data),
        .iss_en_in(iss_en), .iss_rd_in(iss_rd),
        .clr_req_in(clr_req), .clr_busy_out(clr_busy)
    );

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, failures = 0;
    logic [31:0] mregs [NREGS];
    logic        mbusy [NREGS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // kind 0: read data, 1: read busy, 2: clr_busy
    task automatic push(input string tag, input int kind, input int port, input logic [31:0] exp);
        sb.push_back('{tag, kind, port, exp});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.kind == 0 ? rd_data[e.port*XLEN +: XLEN] :
                  e.kind == 1 ? 32'(rd_busy[e.port]) : 32'(clr_busy);
            check(e.tag, obs, e.exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 0; wb_en = 0; iss_en = 0; clr_req = 0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wa(input logic [AW-1:0] a, input logic [31:0] d);
        wa_en = 1; wa_addr = a; wa_data = d;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
    endtask

    task automatic iss(input logic [AW-1:0] a);
        iss_en = 1; iss_rd = a;
    endtask

    initial begin
        logic [31:0] e;
        logic        eb;
        logic [AW-1:0] a;
        #1 rst_n = 0;
        push("reset_clr_busy", 2, 0, 0);
        push("reset_rd0", 0, 0, 0);
        cyc();
        cyc();
        rst_n = 1;

        // reset while a register holds data and is busy
        wa(5, 32'hDEADBEEF);
        cyc();
        idle(); iss(5); rd(0, 5);
        push("pre_reset_rd5", 0, 0, 32'hDEADBEEF);
        cyc();
        idle(); rd(1, 5);
        push("pre_reset_busy5", 1, 0, 1);
        cyc();
        rst_n = 0;
        push("rst_rd_p0", 0, 0, 0);
        push("rst_rd_p1", 0, 1, 0);
        push("rst_busy_p0", 1, 0, 0);
        push("rst_busy_p1", 1, 1, 0);
        push("rst_clr_busy", 2, 0, 0);
        cyc();
        rst_n = 1;
        push("post_rst_rd5", 0, 0, 0);
        push("post_rst_busy5", 1, 1, 0);
        cyc();

        // x0 protection
        wa(0, 32'h12345678); rd(0, 0); rd(1, 0);
        push("x0_same_cycle", 0, 0, 0);
        cyc();
        idle(); iss(0);
        push("x0_next_cycle", 0, 1, 0);
        cyc();
        idle();
        push("x0_busy", 1, 0, 0);
        cyc();

        // write collision, port B wins
        wa(7, 32'hAAAA);
        cyc();
        idle(); wa(7, 32'h1111); wb(7, 32'h2222); rd(0, 7); rd(1, 7);
`ifdef MSRV32_RF_FWD_EN
        push("coll_same_cycle", 0, 0, 32'h2222);
`else
        push("coll_same_cycle", 0, 0, 32'hAAAA);
`endif
        cyc();
        idle();
        push("coll_next_cycle", 0, 1, 32'h2222);
        cyc();
        wa(8, 32'h5555); rd(1, 8);
`ifdef MSRV32_RF_FWD_EN
        push("fwd_a_same_cycle", 0, 1, 32'h5555);
`else
        push("fwd_a_same_cycle", 0, 1, 32'h0);
`endif
        cyc();
        idle();
        push("wa_next_cycle", 0, 1, 32'h5555);
        cyc();

        // scoreboard
        iss(9); rd(0, 9);
        push("sb_before_issue", 1, 0, 0);
        cyc();
        idle();
        push("sb_busy_set", 1, 0, 1);
        cyc();
        wb(9, 32'h99);
        push("sb_write_mask", 1, 0, 0);
        cyc();
        idle();
        push("sb_busy_cleared", 1, 0, 0);
        push("sb_wb_data", 0, 0, 32'h99);
        cyc();
        iss(9); wa(9, 32'h77);
        cyc();
        idle();
        push("sb_set_wins", 1, 0, 1);
        push("sb_set_wins_data", 0, 0, 32'h77);
        cyc();

        // clear sequence
        for (int i = 1; i < NREGS; i++) begin
            idle();
            if (i % 2) wa(AW'(i), 32'hC0DE0000 + 32'(i));
            else wb(AW'(i), 32'hC0DE0000 + 32'(i));
            cyc();
        end
        idle(); iss(3);
        cyc();
        idle(); iss(20); rd(0, 31); rd(1, 3);
        push("pre_clr_rd31", 0, 0, 32'hC0DE001F);
        push("pre_clr_busy3", 1, 1, 1);
        cyc();
        idle(); clr_req = 1;
        push("clr_req_cycle", 2, 0, 0);
        cyc();
        for (int i = 0; i < NREGS - 1; i++) begin
            idle(); wa(31, 32'hFFFF); wb(2, 32'hEEEE); iss(5);
            clr_req = (i == 5);
            rd(0, 31); rd(1, 1);
            push($sformatf("clr_busy_%0d", i), 2, 0, 1);
            push($sformatf("clr_rd31_%0d", i), 0, 0, 32'hC0DE001F);
            push($sformatf("clr_rd1_%0d", i), 0, 1, i == 0 ? 32'hC0DE0001 : 32'h0);
            cyc();
        end
        idle();
        push("clr_done", 2, 0, 0);
        cyc();
        for (int i = 0; i < NREGS; i++) begin
            rd(0, AW'(i)); rd(1, AW'(i));
            push($sformatf("post_clr_rd%0d", i), 0, 0, 0);
            push($sformatf("post_clr_busy%0d", i), 1, 1, 0);
            cyc();
        end
        push("clr_idle_still", 2, 0, 0);
        cyc();

        // reset mid-clear
        wa(30, 32'hABC); wb(2, 32'h222);
        cyc();
        idle(); clr_req = 1;
        cyc();
        idle();
        for (int i = 0; i < 10; i++) begin
            push($sformatf("mid_clr_busy_%0d", i), 2, 0, 1);
            cyc();
        end
        rst_n = 0;
        #1;
        push("abort_clr_busy", 2, 0, 0);
        drain();
        cyc();
        rst_n = 1;
        rd(0, 30); rd(1, 2);
        push("abort_rd30", 0, 0, 0);
        push("abort_rd2", 0, 1, 0);
        push("abort_idle", 2, 0, 0);
        cyc();
        wa(30, 32'h1234);
        cyc();
        idle();
        push("abort_write_ok", 0, 0, 32'h1234);
        push("abort_still_idle", 2, 0, 0);
        cyc();

        // random traffic against a reference model
        rst_n = 0;
        cyc();
        rst_n = 1;
        for (int r = 0; r < NREGS; r++) begin
            mregs[r] = '0;
            mbusy[r] = 1'b0;
        end
        for (int n = 0; n < 300; n++) begin
            idle();
            if ($urandom_range(0, 1)) wa(AW'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 2) == 0) wb(AW'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 1)) iss(AW'($urandom_range(0, 15)));
            for (int p = 0; p < NRD; p++) begin
                a = AW'($urandom_range(0, 15));
                rd(p, a);
                e = mregs[a];
`ifdef MSRV32_RF_FWD_EN
                if (wa_en && wa_addr != 0 && wa_addr == a) e = wa_data;
                if (wb_en && wb_addr != 0 && wb_addr == a) e = wb_data;
`endif
                if (a == 0) e = 0;
                eb = mbusy[a] && !((wa_en && wa_addr == a) || (wb_en && wb_addr == a));
                push($sformatf("rnd%0d_rd_p%0d", n, p), 0, p, e);
                push($sformatf("rnd%0d_busy_p%0d", n, p), 1, p, 32'(eb));
            end
            cyc();
            if (wa_en && wa_addr != 0) begin
                mregs[wa_addr] = wa_data;
                mbusy[wa_addr] = 1'b0;
            end
            if (wb_en && wb_addr != 0) begin
                mregs[wb_addr] = wb_data;
                mbusy[wb_addr] = 1'b0;
            end
            if (iss_en && iss_rd != 0) mbusy[iss_rd] = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
